ahbextarbiter: RTL and testbench
================================

# ahbextarbiter

Two-manager AHB-Lite arbiter that shares the external memory port (HSELEXT/HADDR/HWDATA… toward HRDATAEXT/HREADYEXT/HRESPEXT) between the Wally core bus (M0) and a second manager such as a DMA or debug module (M1). It sits between the managers and the SoC's external AHB outputs. It tracks address-phase and data-phase ownership separately and hands over only at legal AHB boundaries: never mid fixed-length burst, never inside an INCR run, never under HMASTLOCK. It uses two-way round-robin priority.

## Interface
- PA_BITS, from config_pkg, physical address width
- AHBW, from config_pkg, data bus width
- XLEN, from config_pkg, strobe width is XLEN/8
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- HADDRM0/M1  in  PA_BITS  manager address
- HTRANSM0/M1  in  2  manager transfer type
- HWRITEM0/M1  in  1  manager write flag
- HSIZEM0/M1, HBURSTM0/M1  in  3 each  manager transfer size and burst type
- HPROTM0/M1  in  4  manager protection
- HMASTLOCKM0/M1  in  1  manager lock
- HWDATAM0/M1  in  AHBW  manager write data
- HWSTRBM0/M1  in  XLEN/8  manager write strobes
- HREADYM0/M1  out  1  per-manager ready
- HRESPM0/M1  out  1  per-manager response
- HRDATAM  out  AHBW  read data, broadcast to both managers
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HWSTRB  out  (widths as above)  external bus
- HSELEXT  out  1  equals HTRANS[1] of the muxed bus
- HRDATAEXT  in  AHBW  external read data
- HREADYEXT, HRESPEXT  in  1 each  external ready and response

## Operation
- AOwner (1 bit) selects the address/control mux. DOwner (1 bit) selects the HWDATA/HWSTRB mux and HRESP routing.
- Request: Req_i = HTRANS_i[1] (NONSEQ or SEQ).
- SwitchOK: asserted when all of the following hold at an edge:
  - HREADYEXT=1
  - the owner's HMASTLOCK=0
  - the owner's HTRANS is one of: IDLE; NONSEQ with HBURST=SINGLE; SEQ that is the last beat of a fixed burst (Remaining==1).
- BUSY never permits a switch. INCR (undefined length) holds ownership until the owner presents IDLE or NONSEQ-SINGLE.
- Next-owner rule: if SwitchOK and the non-owner requests, AOwner toggles. Otherwise AOwner holds; the arbiter parks on the last owner.
- Beat counter (Remaining): updated on accepted transfers by the owner (HREADYEXT=1).
  - NONSEQ loads beatlen(HBURST)-1. beatlen: SINGLE/INCR=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
  - SEQ in a fixed burst decrements.
  - The counter is cleared when AOwner toggles.
- DOwner <= AOwner on every edge with HREADYEXT=1.
- HREADY_i:
  - HREADYEXT if i==AOwner or i==DOwner
  - else 0 if Req_i
  - else 1
- HRESP_i = HRESPEXT if i==DOwner, else 0.
- A stalled non-owner must hold its address; the arbiter never records or replays requests.

## Timing
- Reset values:
  - AOwner=0, DOwner=0, Remaining=0.
  - External bus reflects M0's inputs.
  - HREADYM0=1; HREADYM1=1 if M1 idle, else 0.
  - HRESPM0/M1=0.
- Muxing is combinational; zero added latency on the owner's path.
- Handover: the non-owner's held NONSEQ appears on HADDR/HTRANS the cycle after the SwitchOK edge. If the old owner was IDLE, the external bus carries IDLE for the SwitchOK cycle.
- Write data for the last old-owner address phase is muxed by DOwner during the first new-owner address cycle. No data-phase mixing occurs.
- HREADYEXT=0 freezes AOwner, DOwner and Remaining.
- Reset mid-burst: the state returns to the reset values immediately (asynchronous); the external bus re-sources from M0.

## Structure
- config_pkg additions:
  - HTRANS encodings IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
  - HBURST encodings
  - function beatlen(HBURST)
- Sub-module ahbburstcounter: holds Remaining, takes load/decrement/clear and HBURST, and outputs LastBeat.
- Top level holds the owner registers, SwitchOK logic and muxes.

## Test plan
- M0 only, SINGLE reads at 0x8000_0000 with HREADYEXT=1 → AOwner stays 0; HREADYM0 tracks HREADYEXT; HREADYM1=1.
- M0 issues INCR4 and M1 issues NONSEQ at beat 2 → M1 stalled (HREADYM1=0) through beat 4; M1 address on the bus the cycle after the beat-4 edge; DOwner=1 one cycle later.
- Both request single transfers every cycle → grants alternate M0, M1, M0… with no bubble; HWDATA follows DOwner.
- M1 owns with HMASTLOCK=1 across three singles while M0 requests → no switch until an edge where HMASTLOCKM1=0.
- HREADYEXT held low 5 cycles during a handover edge → AOwner/DOwner unchanged until HREADYEXT rises; HRESPEXT=1 routed only to DOwner.
- Reset asserted mid-INCR8 owned by M1 → AOwner=0, Remaining=0 asynchronously; bus shows M0 inputs.

Source files
------------

// File: rtl/ahbextarbiter_pkg.sv
// Shared bus widths, AHB encodings and burst helpers for the external-port arbiter.
package ahbextarbiter_pkg;

   localparam int PA_BITS = 32;
   localparam int AHBW    = 32;
   localparam int XLEN    = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Address-phase control of one manager, muxed as a single bundle.
   typedef struct packed {
      logic [PA_BITS-1:0] haddr;
      logic [1:0]         htrans;
      logic               hwrite;
      logic [2:0]         hsize;
      logic [2:0]         hburst;
      logic [3:0]         hprot;
      logic               hmastlock;
   } ahb_ctrl_t;

   // Number of beats in a burst; undefined-length INCR counts as one.
   function automatic logic [4:0] beatlen(input logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4, HBURST_INCR4:   beatlen = 5'd4;
         HBURST_WRAP8, HBURST_INCR8:   beatlen = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: beatlen = 5'd16;
         default:                      beatlen = 5'd1;
      endcase
   endfunction

   // Fixed-length bursts are everything except SINGLE and INCR.
   function automatic logic is_fixed(input logic [2:0] hburst);
      is_fixed = (hburst[2:1] != 2'b00);
   endfunction

endpackage

// File: rtl/ahbextarbiter_burstcounter.sv
// Remaining-beat counter for the current address-phase owner's burst.
module ahbburstcounter
   import ahbextarbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       dec,
   input  logic       clear,
   input  logic [2:0] hburst,
   output logic       last_beat
);

   logic [3:0] remaining;

   // Clear on handover wins; a NONSEQ loads beats-1, fixed-burst SEQ counts down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         remaining <= 4'd0;
      else if (clear)
         remaining <= 4'd0;
      else if (load)
         remaining <= 4'(beatlen(hburst) - 5'd1);
      else if (dec && (remaining != 4'd0))
         remaining <= remaining - 4'd1;
   end

   assign last_beat = (remaining == 4'd1);

endmodule

// File: rtl/ahbextarbiter.sv
// Two-manager AHB-Lite arbiter for the external memory port, round-robin,
// handing over only at transfer/burst boundaries outside locked sequences.
module ahbextarbiter
   import ahbextarbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PA_BITS-1:0]   HADDRM0,
   input  logic [PA_BITS-1:0]   HADDRM1,
   input  logic [1:0]           HTRANSM0,
   input  logic [1:0]           HTRANSM1,
   input  logic                 HWRITEM0,
   input  logic                 HWRITEM1,
   input  logic [2:0]           HSIZEM0,
   input  logic [2:0]           HSIZEM1,
   input  logic [2:0]           HBURSTM0,
   input  logic [2:0]           HBURSTM1,
   input  logic [3:0]           HPROTM0,
   input  logic [3:0]           HPROTM1,
   input  logic                 HMASTLOCKM0,
   input  logic                 HMASTLOCKM1,
   input  logic [AHBW-1:0]      HWDATAM0,
   input  logic [AHBW-1:0]      HWDATAM1,
   input  logic [XLEN/8-1:0]    HWSTRBM0,
   input  logic [XLEN/8-1:0]    HWSTRBM1,
   output logic                 HREADYM0,
   output logic                 HREADYM1,
   output logic                 HRESPM0,
   output logic                 HRESPM1,
   output logic [AHBW-1:0]      HRDATAM,
   output logic [PA_BITS-1:0]   HADDR,
   output logic [1:0]           HTRANS,
   output logic                 HWRITE,
   output logic [2:0]           HSIZE,
   output logic [2:0]           HBURST,
   output logic [3:0]           HPROT,
   output logic                 HMASTLOCK,
   output logic [AHBW-1:0]      HWDATA,
   output logic [XLEN/8-1:0]    HWSTRB,
   output logic                 HSELEXT,
   input  logic [AHBW-1:0]      HRDATAEXT,
   input  logic                 HREADYEXT,
   input  logic                 HRESPEXT
);

   logic      aowner;
   logic      downer;
   ahb_ctrl_t ctrl_m0;
   ahb_ctrl_t ctrl_m1;
   ahb_ctrl_t ctrl;
   logic      req_m0;
   logic      req_m1;
   logic      other_req;
   logic      last_beat;
   logic      boundary;
   logic      switch_ok;
   logic      handover;

   assign ctrl_m0 = '{haddr: HADDRM0, htrans: HTRANSM0, hwrite: HWRITEM0, hsize: HSIZEM0,
                      hburst: HBURSTM0, hprot: HPROTM0, hmastlock: HMASTLOCKM0};
   assign ctrl_m1 = '{haddr: HADDRM1, htrans: HTRANSM1, hwrite: HWRITEM1, hsize: HSIZEM1,
                      hburst: HBURSTM1, hprot: HPROTM1, hmastlock: HMASTLOCKM1};
   assign ctrl    = aowner ? ctrl_m1 : ctrl_m0;

   assign HADDR     = ctrl.haddr;
   assign HTRANS    = ctrl.htrans;
   assign HWRITE    = ctrl.hwrite;
   assign HSIZE     = ctrl.hsize;
   assign HBURST    = ctrl.hburst;
   assign HPROT     = ctrl.hprot;
   assign HMASTLOCK = ctrl.hmastlock;
   assign HSELEXT   = ctrl.htrans[1];
   assign HWDATA    = downer ? HWDATAM1 : HWDATAM0;
   assign HWSTRB    = downer ? HWSTRBM1 : HWSTRBM0;
   assign HRDATAM   = HRDATAEXT;

   assign req_m0    = HTRANSM0[1];
   assign req_m1    = HTRANSM1[1];
   assign other_req = aowner ? req_m0 : req_m1;

   // BUSY and INCR continuation never count as a boundary.
   assign boundary  = (ctrl.htrans == HTRANS_IDLE)
                    | ((ctrl.htrans == HTRANS_NONSEQ) & (ctrl.hburst == HBURST_SINGLE))
                    | ((ctrl.htrans == HTRANS_SEQ) & is_fixed(ctrl.hburst) & last_beat);
   assign switch_ok = HREADYEXT & ~ctrl.hmastlock & boundary;
   assign handover  = switch_ok & other_req;

   // Address owner flips on a legal handover; data owner trails it by one accepted phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aowner <= 1'b0;
         downer <= 1'b0;
      end else begin
         if (handover)
            aowner <= ~aowner;
         if (HREADYEXT)
            downer <= aowner;
      end
   end

   ahbburstcounter u_burstcounter (
      .clk       (clk),
      .reset     (reset),
      .load      (HREADYEXT & (ctrl.htrans == HTRANS_NONSEQ)),
      .dec       (HREADYEXT & (ctrl.htrans == HTRANS_SEQ) & is_fixed(ctrl.hburst)),
      .clear     (handover),
      .hburst    (ctrl.hburst),
      .last_beat (last_beat)
   );

   // A manager that owns neither phase is stalled only while it is requesting.
   assign HREADYM0 = (~aowner | ~downer) ? HREADYEXT : ~req_m0;
   assign HREADYM1 = ( aowner |  downer) ? HREADYEXT : ~req_m1;
   assign HRESPM0  = ~downer & HRESPEXT;
   assign HRESPM1  =  downer & HRESPEXT;

endmodule

// File: tb/tb_ahbextarbiter.sv
// Self-checking bench for ahbextarbiter against an owner/beat-count reference model.
module tb_ahbextarbiter;
   import ahbextarbiter_pkg::*;

   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
   localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5;
   localparam int OBS_W = 19 + PA_BITS + 2*AHBW + XLEN/8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Per-manager stimulus, indexed by manager number.
   logic [PA_BITS-1:0] mt_addr  [2];
   logic [1:0]         mt_trans [2];
   logic               mt_write [2];
   logic [2:0]         mt_size  [2];
   logic [2:0]         mt_burst [2];
   logic [3:0]         mt_prot  [2];
   logic               mt_lock  [2];
   logic [AHBW-1:0]    mt_wdata [2];
   logic [XLEN/8-1:0]  mt_strb  [2];

   logic [AHBW-1:0]    HRDATAEXT;
   logic               HREADYEXT, HRESPEXT;
   logic               HREADYM0, HREADYM1, HRESPM0, HRESPM1, HWRITE, HMASTLOCK, HSELEXT;
   logic [AHBW-1:0]    HRDATAM, HWDATA;
   logic [PA_BITS-1:0] HADDR;
   logic [1:0]         HTRANS;
   logic [2:0]         HSIZE, HBURST;
   logic [3:0]         HPROT;
   logic [XLEN/8-1:0]  HWSTRB;

   ahbextarbiter dut (
      .clk(clk), .reset(reset),
      .HADDRM0(mt_addr[0]), .HADDRM1(mt_addr[1]),
      .HTRANSM0(mt_trans[0]), .HTRANSM1(mt_trans[1]),
      .HWRITEM0(mt_write[0]), .HWRITEM1(mt_write[1]),
      .HSIZEM0(mt_size[0]), .HSIZEM1(mt_size[1]),
      .HBURSTM0(mt_burst[0]), .HBURSTM1(mt_burst[1]),
      .HPROTM0(mt_prot[0]), .HPROTM1(mt_prot[1]),
      .HMASTLOCKM0(mt_lock[0]), .HMASTLOCKM1(mt_lock[1]),
      .HWDATAM0(mt_wdata[0]), .HWDATAM1(mt_wdata[1]),
      .HWSTRBM0(mt_strb[0]), .HWSTRBM1(mt_strb[1]),
      .HREADYM0(HREADYM0), .HREADYM1(HREADYM1),
      .HRESPM0(HRESPM0), .HRESPM1(HRESPM1),
      .HRDATAM(HRDATAM),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
      .HSELEXT(HSELEXT),
      .HRDATAEXT(HRDATAEXT), .HREADYEXT(HREADYEXT), .HRESPEXT(HRESPEXT)
   );

   logic [OBS_W-1:0] obs;
   assign obs = {HREADYM0, HREADYM1, HRESPM0, HRESPM1, HSELEXT, HTRANS, HBURST, HMASTLOCK,
                 HWRITE, HSIZE, HPROT, HADDR, HWDATA, HWSTRB, HRDATAM};

   int checks = 0;
   int fails  = 0;

   // Reference model: who owns each phase, and how many beats of a fixed burst remain.
   int m_aown = 0;
   int m_down = 0;
   int m_rem  = 0;
   int blen_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

   function automatic logic [OBS_W-1:0] exp_obs();
      logic [1:0] rdy;
      logic [1:0] rsp;
      for (int i = 0; i < 2; i++) begin
         if (i == m_aown || i == m_down) rdy[i] = HREADYEXT;
         else                            rdy[i] = ~mt_trans[i][1];
         rsp[i] = (i == m_down) ? HRESPEXT : 1'b0;
      end
      return {rdy[0], rdy[1], rsp[0], rsp[1], mt_trans[m_aown][1], mt_trans[m_aown],
              mt_burst[m_aown], mt_lock[m_aown], mt_write[m_aown], mt_size[m_aown],
              mt_prot[m_aown], mt_addr[m_aown], mt_wdata[m_down], mt_strb[m_down], HRDATAEXT};
   endfunction

   task automatic model_edge();
      int o, n;
      logic [1:0] t;
      logic [2:0] b;
      bit ok;
      if (!HREADYEXT) return;
      o = m_aown;
      n = 1 - o;
      t = mt_trans[o];
      b = mt_burst[o];
      ok = !mt_lock[o] && (t == T_IDLE || (t == T_NSEQ && b == B_SINGLE) || (t == T_SEQ && m_rem == 1));
      m_down = o;
      if (ok && mt_trans[n][1]) begin
         m_aown = n;
         m_rem  = 0;
      end else if (t == T_NSEQ) begin
         m_rem = blen_tab[b] - 1;
      end else if (t == T_SEQ && b >= 3'd2 && m_rem > 0) begin
         m_rem = m_rem - 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_edge();
      #1;
   endtask

   task automatic drive(input int i, input logic [1:0] t, input logic [2:0] b,
                        input logic lk, input logic [PA_BITS-1:0] a);
      mt_trans[i] = t;
      mt_burst[i] = b;
      mt_lock[i]  = lk;
      mt_addr[i]  = a;
      mt_write[i] = 1'($urandom);
      mt_size[i]  = 3'($urandom_range(0, 2));
      mt_prot[i]  = 4'($urandom);
      mt_wdata[i] = $urandom;
      mt_strb[i]  = (XLEN/8)'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1; HREADYEXT = 1'b1; HRESPEXT = 1'b0; HRDATAEXT = $urandom;
      drive(0, T_IDLE, B_SINGLE, 1'b0, 32'h8000_0000);
      drive(1, T_NSEQ, B_SINGLE, 1'b0, 32'h9000_0000);
      m_aown = 0; m_down = 0; m_rem = 0;
      #1;
      checks++;
      if (obs !== exp_obs()) begin fails++; $display("FAIL reset_vec: got %h want %h", obs, exp_obs()); end
      checks++;
      if ({HREADYM0, HREADYM1, HRESPM0, HRESPM1} !== 4'b1000) begin
         fails++; $display("FAIL reset_ready_resp: got %b want 1000", {HREADYM0, HREADYM1, HRESPM0, HRESPM1});
      end
      checks++;
      if (HADDR !== 32'h8000_0000) begin fails++; $display("FAIL reset_haddr: got %h want 80000000", HADDR); end
      drive(1, T_IDLE, B_SINGLE, 1'b0, 32'h9000_0000);
      #1;
      checks++;
      if (HREADYM1 !== 1'b1) begin fails++; $display("FAIL reset_m1_idle_ready: got %b want 1", HREADYM1); end
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_m0_single();
      for (int k = 0; k < 8; k++) begin
         HREADYEXT = (k == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         HRDATAEXT = $urandom;
         drive(0, T_NSEQ, B_SINGLE, 1'b0, 32'h8000_0000 + PA_BITS'(4*k));
         drive(1, T_IDLE, B_SINGLE, 1'b0, 32'h9000_0000);
         #1;
         checks++;
         if (obs !== exp_obs()) begin fails++; $display("FAIL m0_single_vec k=%0d: got %h want %h", k, obs, exp_obs()); end
         checks++;
         if (HADDR !== 32'h8000_0000 + PA_BITS'(4*k) || HREADYM1 !== 1'b1 || HREADYM0 !== HREADYEXT) begin
            fails++; $display("FAIL m0_single k=%0d: got addr %h rdy1 %b rdy0 %b", k, HADDR, HREADYM1, HREADYM0);
         end
         tick();
      end
   endtask

   task automatic test_burst_handover();
      logic [PA_BITS-1:0] a0, a1;
      a0 = 32'h8000_1000;
      a1 = 32'h9000_2000;
      HREADYEXT = 1'b1; HRESPEXT = 1'b0;
      for (int k = 0; k < 6; k++) begin
         HRDATAEXT = $urandom;
         if (k == 0)      drive(0, T_NSEQ, B_INCR4, 1'b0, a0);
         else if (k < 4)  drive(0, T_SEQ, B_INCR4, 1'b0, a0 + PA_BITS'(4*k));
         else             drive(0, T_IDLE, B_SINGLE, 1'b0, a0);
         if (k >= 2 && k <= 4) drive(1, T_NSEQ, B_SINGLE, 1'b0, a1);
         else                  drive(1, T_IDLE, B_SINGLE, 1'b0, a1);
         #1;
         checks++;
         if (obs !== exp_obs()) begin fails++; $display("FAIL burst_vec k=%0d: got %h want %h", k, obs, exp_obs()); end
         if (k == 2 || k == 3) begin
            checks++;
            if (HREADYM1 !== 1'b0 || HADDR !== a0 + PA_BITS'(4*k)) begin
               fails++; $display("FAIL burst_m1_stall k=%0d: got rdy1 %b addr %h", k, HREADYM1, HADDR);
            end
         end
         if (k == 4) begin
            checks++;
            if (HADDR !== a1 || HTRANS !== T_NSEQ || HWDATA !== mt_wdata[0]) begin
               fails++; $display("FAIL burst_handover: got addr %h trans %0d wdata %h want %h %0d %h",
                                 HADDR, HTRANS, HWDATA, a1, T_NSEQ, mt_wdata[0]);
            end
         end
         if (k == 5) begin
            checks++;
            if (HWDATA !== mt_wdata[1]) begin fails++; $display("FAIL burst_downer: got %h want %h", HWDATA, mt_wdata[1]); end
         end
         tick();
      end
   endtask

   task automatic test_alternate();
      int prev, cur;
      HREADYEXT = 1'b1; HRESPEXT = 1'b0;
      prev = -1;
      for (int k = 0; k < 10; k++) begin
         HRDATAEXT = $urandom;
         drive(0, T_NSEQ, B_SINGLE, 1'b0, 32'h8000_0000 + PA_BITS'(16*k));
         drive(1, T_NSEQ, B_SINGLE, 1'b0, 32'h9000_0000 + PA_BITS'(16*k));
         #1;
         cur = (HADDR[PA_BITS-1 -: 4] == 4'h9) ? 1 : 0;
         checks++;
         if (obs !== exp_obs()) begin fails++; $display("FAIL alternate_vec k=%0d: got %h want %h", k, obs, exp_obs()); end
         if (k > 0) begin
            checks++;
            if (cur == prev) begin fails++; $display("FAIL alternate_owner k=%0d: got owner %0d want %0d", k, cur, 1 - prev); end
            checks++;
            if (HWDATA !== mt_wdata[prev]) begin fails++; $display("FAIL alternate_wdata k=%0d: got %h want %h", k, HWDATA, mt_wdata[prev]); end
         end
         prev = cur;
         tick();
      end
   endtask

   task automatic test_lock();
      HREADYEXT = 1'b1; HRESPEXT = 1'b0; HRDATAEXT = $urandom;
      drive(0, T_IDLE, B_SINGLE, 1'b0, 32'h8000_0100);
      drive(1, T_NSEQ, B_SINGLE, 1'b0, 32'h9000_00F0);
      #1;
      checks++;
      if (obs !== exp_obs()) begin fails++; $display("FAIL lock_setup_vec: got %h want %h", obs, exp_obs()); end
      tick();
      for (int k = 0; k < 5; k++) begin
         HRDATAEXT = $urandom;
         drive(0, T_NSEQ, B_SINGLE, 1'b0, 32'h8000_0100);
         drive(1, T_NSEQ, B_SINGLE, (k < 3) ? 1'b1 : 1'b0, 32'h9000_0100 + PA_BITS'(4*k));
         #1;
         checks++;
         if (obs !== exp_obs()) begin fails++; $display("FAIL lock_vec k=%0d: got %h want %h", k, obs, exp_obs()); end
         checks++;
         if (k < 4 && HADDR !== 32'h9000_0100 + PA_BITS'(4*k)) begin
            fails++; $display("FAIL lock_hold k=%0d: got %h want %h", k, HADDR, 32'h9000_0100 + PA_BITS'(4*k));
         end else if (k == 4 && HADDR !== 32'h8000_0100) begin
            fails++; $display("FAIL lock_release: got %h want 80000100", HADDR);
         end
         if (k < 4) tick();
      end
   endtask

   task automatic test_stall();
      int own0;
      own0 = m_aown;
      drive(0, T_NSEQ, B_SINGLE, 1'b0, 32'h8000_0200);
      drive(1, T_NSEQ, B_SINGLE, 1'b0, 32'h9000_0200);
      HREADYEXT = 1'b0; HRESPEXT = 1'b1;
      for (int k = 0; k < 5; k++) begin
         HRDATAEXT = $urandom;
         #1;
         checks++;
         if (obs !== exp_obs()) begin fails++; $display("FAIL stall_vec k=%0d: got %h want %h", k, obs, exp_obs()); end
         checks++;
         if (HADDR !== mt_addr[own0] || (HRESPM0 & HRESPM1) !== 1'b0 || (HRESPM0 | HRESPM1) !== 1'b1) begin
            fails++; $display("FAIL stall_hold k=%0d: got addr %h resp %b%b want addr %h", k, HADDR, HRESPM0, HRESPM1, mt_addr[own0]);
         end
         tick();
      end
      HREADYEXT = 1'b1; HRESPEXT = 1'b0;
      #1;
      checks++;
      if (obs !== exp_obs()) begin fails++; $display("FAIL stall_release_vec: got %h want %h", obs, exp_obs()); end
      tick();
      checks++;
      if (HADDR !== mt_addr[1 - own0]) begin fails++; $display("FAIL stall_handover: got %h want %h", HADDR, mt_addr[1 - own0]); end
   endtask

   task automatic test_reset_mid_burst();
      logic [PA_BITS-1:0] c, d;
      c = 32'h9000_4000;
      d = 32'h8000_4444;
      HREADYEXT = 1'b1; HRESPEXT = 1'b0;
      drive(0, T_IDLE, B_SINGLE, 1'b0, d);
      drive(1, T_NSEQ, B_INCR8, 1'b0, c);
      for (int k = 0; k < 3 && m_aown != 1; k++) begin
         #1;
         checks++;
         if (obs !== exp_obs()) begin fails++; $display("FAIL rstburst_setup_vec: got %h want %h", obs, exp_obs()); end
         tick();
      end
      #1;
      checks++;
      if (HADDR !== c) begin fails++; $display("FAIL rstburst_owner: got %h want %h", HADDR, c); end
      tick();
      for (int k = 1; k < 4; k++) begin
         drive(1, T_SEQ, B_INCR8, 1'b0, c + PA_BITS'(4*k));
         drive(0, T_NSEQ, B_SINGLE, 1'b0, d);
         #1;
         checks++;
         if (HADDR !== c + PA_BITS'(4*k) || obs !== exp_obs()) begin
            fails++; $display("FAIL rstburst_hold k=%0d: got %h want %h", k, obs, exp_obs());
         end
         tick();
      end
      drive(1, T_SEQ, B_INCR8, 1'b0, c + 32'd16);
      #2;
      reset = 1'b1;
      m_aown = 0; m_down = 0; m_rem = 0;
      #1;
      checks++;
      if (HADDR !== d || HTRANS !== T_NSEQ || HREADYM0 !== 1'b1 || HREADYM1 !== 1'b0) begin
         fails++; $display("FAIL rstburst_async: got addr %h trans %0d rdy %b%b want %h 2 10", HADDR, HTRANS, HREADYM0, HREADYM1, d);
      end
      checks++;
      if (obs !== exp_obs()) begin fails++; $display("FAIL rstburst_vec: got %h want %h", obs, exp_obs()); end
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== exp_obs()) begin fails++; $display("FAIL rstburst_release_vec: got %h want %h", obs, exp_obs()); end
      tick();
   endtask

   task automatic test_random();
      logic [1:0] t;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 2; i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2: t = T_IDLE;
               3:       t = T_BUSY;
               4, 5:    t = T_NSEQ;
               default: t = T_SEQ;
            endcase
            drive(i, t, 3'($urandom), 1'($urandom_range(0, 7) == 0),
                  {(i == 0) ? 4'h8 : 4'h9, (PA_BITS-4)'($urandom)});
         end
         HREADYEXT = 1'($urandom_range(0, 3) != 0);
         HRESPEXT  = 1'($urandom_range(0, 3) == 0);
         HRDATAEXT = $urandom;
         #1;
         checks++;
         if (obs !== exp_obs()) begin fails++; $display("FAIL random_vec k=%0d: got %h want %h", k, obs, exp_obs()); end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_m0_single();
      test_burst_handover();
      test_alternate();
      test_lock();
      test_stall();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
